// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types, constants and helpers for the EX-stage
// iterative multiply/divide sequencer (RV32M).
//   mduop_t     - M-extension operation in funct3 order
//   mdu_state_t - sequencer FSM states
//   ex_mdu_in_t - operand bundle handed over from EX
`ifndef MDU_PKG_SV
`define MDU_PKG_SV

package mdu_pkg;

    localparam int MDU_XLEN = 32;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mduop_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_t;

    localparam logic [MDU_XLEN-1:0] DIV0_Q  = 32'hFFFF_FFFF;
    localparam logic [MDU_XLEN-1:0] MIN_INT = 32'h8000_0000;

    typedef struct packed {
        mduop_t                mduop;
        logic [MDU_XLEN-1:0]   opr_a;
        logic [MDU_XLEN-1:0]   opr_b;
    } ex_mdu_in_t;

    // Multiply ops occupy funct3 0..3, divide/remainder ops 4..7.
    function automatic logic op_is_mul(input mduop_t op);
        return ~op[2];
    endfunction

    function automatic logic op_is_rem(input mduop_t op);
        return op[2] & op[1];
    endfunction

    function automatic logic op_a_signed(input mduop_t op);
        logic r;
        case (op)
            MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM: r = 1'b1;
            default:                                          r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic op_b_signed(input mduop_t op);
        logic r;
        case (op)
            MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM: r = 1'b1;
            default:                             r = 1'b0;
        endcase
        return r;
    endfunction

    // Divide-by-zero and signed overflow finish without iterating.
    function automatic logic fast_path(input mduop_t op,
                                       input logic [MDU_XLEN-1:0] a,
                                       input logic [MDU_XLEN-1:0] b);
        logic div0;
        logic ovf;
        div0 = (b == {MDU_XLEN{1'b0}});
        ovf  = op_b_signed(op) && (a == MIN_INT) && (b == DIV0_Q);
        return op[2] && (div0 || ovf);
    endfunction

    function automatic logic [MDU_XLEN-1:0] fast_result(input mduop_t op,
                                                        input logic [MDU_XLEN-1:0] a,
                                                        input logic [MDU_XLEN-1:0] b);
        logic [MDU_XLEN-1:0] r;
        if (b == {MDU_XLEN{1'b0}}) begin
            r = op_is_rem(op) ? a : DIV0_Q;
        end else begin
            r = op_is_rem(op) ? {MDU_XLEN{1'b0}} : MIN_INT;
        end
        return r;
    endfunction

endpackage

`endif

// File: rtl/ex_mdu_dp.sv
// ex_mdu_dp: shared shift/add-subtract datapath for the MDU.
//   ld_i      - capture op, signs and operand magnitudes
//   step_i    - one radix-2 multiply or restoring-divide iteration
//   fin_i     - register the sign-fixed result of the final iteration
//   fast_i    - register fast_res_i as the result (no iteration)
//   res_o     - registered result
module ex_mdu_dp
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            ld_i,
    input  logic            step_i,
    input  logic            fin_i,
    input  logic            fast_i,
    input  logic [2:0]      mduop_i,
    input  logic [XLEN-1:0] opr_a_i,
    input  logic [XLEN-1:0] opr_b_i,
    input  logic [XLEN-1:0] fast_res_i,
    output logic [XLEN-1:0] res_o
);

    mduop_t            op_in_s;
    mduop_t            op_q, op_d;
    logic              neg_q, neg_d;          // product / quotient negative
    logic              neg_rem_q, neg_rem_d;  // dividend negative
    logic [XLEN-1:0]   opnd_q, opnd_d;        // multiplicand or divisor
    logic [XLEN-1:0]   hi_q, hi_d;            // product high / partial remainder
    logic [XLEN-1:0]   lo_q, lo_d;            // multiplier / dividend-quotient
    logic [XLEN-1:0]   res_q, res_d;

    logic              a_neg_s, b_neg_s;
    logic [XLEN-1:0]   a_mag_s, b_mag_s;
    logic [XLEN:0]     add_a_s, add_b_s;
    logic              cin_s;
    logic [XLEN+1:0]   sum_s;
    logic [2*XLEN-1:0] prod_s, prod_fix_s;
    logic [XLEN-1:0]   fin_res_s;

    assign op_in_s = mduop_t'(mduop_i);
    assign res_o   = res_q;

    // Operand sign detection and magnitude conversion at load
    always_comb begin
        a_neg_s = op_a_signed(op_in_s) & opr_a_i[XLEN-1];
        b_neg_s = op_b_signed(op_in_s) & opr_b_i[XLEN-1];
        a_mag_s = a_neg_s ? -opr_a_i : opr_a_i;
        b_mag_s = b_neg_s ? -opr_b_i : opr_b_i;
    end

    // Single adder: accumulate for multiply, trial-subtract for divide
    always_comb begin
        if (op_is_mul(op_q)) begin
            add_a_s = {1'b0, hi_q};
            add_b_s = lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}};
            cin_s   = 1'b0;
        end else begin
            add_a_s = {hi_q, lo_q[XLEN-1]};
            add_b_s = ~{1'b0, opnd_q};
            cin_s   = 1'b1;
        end
        sum_s = {1'b0, add_a_s} + {1'b0, add_b_s} + {{(XLEN+1){1'b0}}, cin_s};
    end

    // Next-state of the working registers
    always_comb begin
        op_d      = op_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (ld_i) begin
            op_d      = op_in_s;
            neg_d     = a_neg_s ^ b_neg_s;
            neg_rem_d = a_neg_s;
            hi_d      = {XLEN{1'b0}};
            if (op_is_mul(op_in_s)) begin
                opnd_d = a_mag_s;
                lo_d   = b_mag_s;
            end else begin
                opnd_d = b_mag_s;
                lo_d   = a_mag_s;
            end
        end else if (step_i) begin
            if (op_is_mul(op_q)) begin
                // Carry goes into the top bit; the sum LSB drops into the low word.
                hi_d = sum_s[XLEN:1];
                lo_d = {sum_s[0], lo_q[XLEN-1:1]};
            end else if (sum_s[XLEN+1]) begin
                // No borrow: keep the difference, quotient bit 1.
                hi_d = sum_s[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = add_a_s[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_d = hi_q;
        end
    end

    // Sign fix on the post-step values so the result registers on DONE entry
    always_comb begin
        prod_s     = {hi_d, lo_d};
        prod_fix_s = neg_q ? -prod_s : prod_s;
        case (op_q)
            MDU_MUL:                         fin_res_s = prod_fix_s[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: fin_res_s = prod_fix_s[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:               fin_res_s = neg_q ? -lo_d : lo_d;
            MDU_REM, MDU_REMU:               fin_res_s = neg_rem_q ? -hi_d : hi_d;
            default:                         fin_res_s = {XLEN{1'b0}};
        endcase
    end

    // Result register: only fast path or a completed iteration updates it
    always_comb begin
        if (fast_i) begin
            res_d = fast_res_i;
        end else if (fin_i) begin
            res_d = fin_res_s;
        end else begin
            res_d = res_q;
        end
    end

    // Datapath state flops
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            op_q      <= MDU_MUL;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= {XLEN{1'b0}};
            hi_q      <= {XLEN{1'b0}};
            lo_q      <= {XLEN{1'b0}};
            res_q     <= {XLEN{1'b0}};
        end else begin
            op_q      <= op_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            res_q     <= res_d;
        end
    end

endmodule

// File: rtl/ex_mdu_seq_chk.sv
// ex_mdu_seq_chk: protocol checks for the multiply/divide sequencer.
//   clk, arst_n  - clock and async active-low reset
//   start_i      - EX M-op valid level
//   flush_i      - EX kill
//   running_i    - sequencer is iterating (MUL or DIV state)
module ex_mdu_seq_chk (
    input logic clk,
    input logic arst_n,
    input logic start_i,
    input logic flush_i,
    input logic running_i
);

    // EX must keep the M-op presented for the whole iteration unless it is killed
    a_start_held: assert property (@(posedge clk) disable iff (!arst_n)
                                   (running_i && !flush_i) |-> start_i)
        else $error("ex_mdu_seq: start_i dropped during iteration without flush_i");

endmodule

// File: rtl/ex_mdu_seq.sv
// ex_mdu_seq: iterative RV32M multiply/divide sequencer beside the EX ALU.
//   clk, arst_n      - clock, async active-low reset
//   start_i          - EX holds a valid M-op (level, held while stalled)
//   mduop_i          - funct3 op code (mduop_t)
//   opr_a_i, opr_b_i - forwarded rs1/rs2
//   flush_i          - kill of the EX instruction (highest priority)
//   busy_o           - combinational stall request to IF/ID/EX
//   done_o           - registered one-cycle result-valid pulse
//   res_o            - registered result
module ex_mdu_seq
    import mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            start_i,
    input  logic [2:0]      mduop_i,
    input  logic [XLEN-1:0] opr_a_i,
    input  logic [XLEN-1:0] opr_b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] res_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    mdu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    mduop_t           op_in_s;
    logic             fast_hit_s;
    logic [XLEN-1:0]  fast_res_s;
    logic             ld_s, step_s, fin_s, fast_s;
    logic             running_s;

    assign op_in_s    = mduop_t'(mduop_i);
    assign fast_hit_s = fast_path(op_in_s, opr_a_i, opr_b_i);
    assign fast_res_s = fast_result(op_in_s, opr_a_i, opr_b_i);
    assign running_s  = (state_q == ST_MUL) || (state_q == ST_DIV);

    // Stall is combinational so the M-op is held from its first EX cycle.
    assign busy_o = !flush_i && (((state_q == ST_IDLE) && start_i) || running_s);
    assign done_o = done_q;

    // Sequencer next-state and datapath strobes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        ld_s    = 1'b0;
        step_s  = 1'b0;
        fin_s   = 1'b0;
        fast_s  = 1'b0;
        if (flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        ld_s = 1'b1;
                        if (fast_hit_s) begin
                            fast_s  = 1'b1;
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end else if (op_is_mul(op_in_s)) begin
                            state_d = ST_MUL;
                        end else begin
                            state_d = ST_DIV;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_MUL, ST_DIV: begin
                    step_s = 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        fin_s   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                // start_i here still belongs to the instruction leaving EX.
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Sequencer state, iteration counter and done pulse
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    ex_mdu_dp #(
        .XLEN (XLEN)
    ) u_dp (
        .clk        (clk),
        .arst_n     (arst_n),
        .ld_i       (ld_s),
        .step_i     (step_s),
        .fin_i      (fin_s),
        .fast_i     (fast_s),
        .mduop_i    (mduop_i),
        .opr_a_i    (opr_a_i),
        .opr_b_i    (opr_b_i),
        .fast_res_i (fast_res_s),
        .res_o      (res_o)
    );

    ex_mdu_seq_chk u_chk (
        .clk       (clk),
        .arst_n    (arst_n),
        .start_i   (start_i),
        .flush_i   (flush_i),
        .running_i (running_s)
    );

endmodule

// File: tb/tb_ex_mdu_seq.sv
// tb_ex_mdu_seq: self-checking bench for ex_mdu_seq. Vector table plus
// hand-written flush / mid-op reset / back-to-back sequences; expected
// results go through a scoreboard queue and are popped on done_o.
module tb_ex_mdu_seq;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        start_i;
    logic [2:0]  mduop_i;
    logic [31:0] opr_a_i;
    logic [31:0] opr_b_i;
    logic        flush_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] res_o;

    typedef struct {
        mduop_t      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int          checks = 0;
    int          passed = 0;
    logic [31:0] last_res = 32'h0;

    ex_mdu_seq dut (
        .clk     (clk),
        .arst_n  (arst_n),
        .start_i (start_i),
        .mduop_i (mduop_i),
        .opr_a_i (opr_a_i),
        .opr_b_i (opr_b_i),
        .flush_i (flush_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .res_o   (res_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add_vec(input mduop_t op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Drive one op from an IDLE cycle, track it to done_o and score it.
    task automatic do_op(input mduop_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat, input bit hold, input string name);
        int   k;
        int   busy_cnt;
        bit   seen;
        exp_t e;
        @(negedge clk);
        mduop_i = op; opr_a_i = a; opr_b_i = b; start_i = 1'b1; flush_i = 1'b0;
        e.res = res; e.lat = lat;
        sb.push_back(e);
        #1;
        busy_cnt = busy_o ? 1 : 0;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 60) begin
            @(posedge clk); #1;
            k++;
            if (done_o) seen = 1'b1;
            else if (busy_o) busy_cnt++;
        end
        if (!seen) begin
            checks++;
            $display("FAIL %s timeout: no done_o after %0d cycles, required %0d", name, k, lat);
            if (sb.size() > 0) void'(sb.pop_front());
            @(negedge clk); flush_i = 1'b1; start_i = 1'b0;
            @(negedge clk); flush_i = 1'b0;
        end else begin
            chk({name, " latency"}, 32'(k), 32'(lat));
            chk({name, " busy cycles"}, 32'(busy_cnt), 32'(lat));
            chk({name, " busy in done"}, 32'(busy_o), 32'h0);
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL %s: done_o with empty scoreboard, got %h", name, res_o);
            end else begin
                e = sb.pop_front();
                chk({name, " result"}, res_o, e.res);
                last_res = e.res;
            end
            @(negedge clk);
            if (!hold) start_i = 1'b0;
            @(posedge clk); #1;
            chk({name, " done pulse"}, 32'(done_o), 32'h0);
        end
    endtask

    initial begin
        int dones;
        arst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
        mduop_i = 3'd0; opr_a_i = 32'h0; opr_b_i = 32'h0;
        #1;
        chk("reset busy", 32'(busy_o), 32'h0);
        chk("reset done", 32'(done_o), 32'h0);
        chk("reset res",  res_o, 32'h0);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;

        add_vec(MDU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        add_vec(MDU_MULH,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        add_vec(MDU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        add_vec(MDU_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        add_vec(MDU_MUL,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33);
        add_vec(MDU_MULH,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 33);
        add_vec(MDU_DIV,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 33);
        add_vec(MDU_REM,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 33);
        add_vec(MDU_DIVU,   32'd100,        32'd7,         32'd14,        33);
        add_vec(MDU_REMU,   32'd100,        32'd7,         32'd2,         33);
        add_vec(MDU_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        add_vec(MDU_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         33);
        add_vec(MDU_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         33);
        add_vec(MDU_REMU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33);
        add_vec(MDU_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        add_vec(MDU_REM,    32'd5,          32'd0,         32'd5,         1);
        add_vec(MDU_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        add_vec(MDU_REMU,   32'd5,          32'd0,         32'd5,         1);
        add_vec(MDU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        add_vec(MDU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, 1'b0,
                  $sformatf("vec%0d", i));
        end

        // Flush in cycle 10 of a divide: stall drops at once, no result.
        @(negedge clk);
        mduop_i = MDU_DIVU; opr_a_i = 32'd1000; opr_b_i = 32'd7; start_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        flush_i = 1'b1; start_i = 1'b0;
        #1;
        chk("flush busy", 32'(busy_o), 32'h0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done_o) dones++;
        end
        chk("flush no done", 32'(dones), 32'h0);
        chk("flush idle busy", 32'(busy_o), 32'h0);
        chk("flush res kept", res_o, last_res);
        do_op(MDU_MUL, 32'd2, 32'd3, 32'd6, 33, 1'b0, "mul after flush");

        // Async reset in the middle of a multiply.
        @(negedge clk);
        mduop_i = MDU_MUL; opr_a_i = 32'd123; opr_b_i = 32'd456; start_i = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b0; start_i = 1'b0;
        #1;
        chk("midop reset busy", 32'(busy_o), 32'h0);
        chk("midop reset done", 32'(done_o), 32'h0);
        chk("midop reset res",  res_o, 32'h0);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;

        // Back-to-back: start stays high through DONE into the next IDLE.
        do_op(MDU_MUL,  32'd4, 32'd5, 32'd20, 33, 1'b1, "b2b mul");
        do_op(MDU_DIVU, 32'd9, 32'd2, 32'd4,  33, 1'b0, "b2b divu");

        chk("scoreboard drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ex_mdu_seq.md
Name: ex_mdu_seq

Overview:
Iterative multiply/divide sequencer for RV32M, attached beside the ALU in the EX stage.
- Accepts one M-extension op from EX and holds the pipeline via a stall request while it iterates.
- Returns the 32-bit result in the cycle the held instruction is released to MEM. That result is muxed into opr_res.
- Owns the shared shift/add datapath. Only one operation is in flight at a time.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override)

Ports:
clk      in   1     clock
arst_n   in   1     asynchronous active-low reset
start_i  in   1     EX holds a valid M-op (level; stays high while stalled)
mduop_i  in   3     mduop_t: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (funct3 encoding)
opr_a_i  in   XLEN  rs1 operand (post-forwarding)
opr_b_i  in   XLEN  rs2 operand (post-forwarding)
flush_i  in   1     branch/kill of the EX instruction
busy_o   out  1     stall request to IF/ID/EX pipeline registers
done_o   out  1     result valid; one-cycle pulse
res_o    out  XLEN  result, valid when done_o

Behaviour:
- Reset (arst_n low, asynchronous): state=IDLE, counter=0, res_o=0, done_o=0, internal regs=0. busy_o=0 after reset.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - On start_i && !flush_i, latch op, signedness and operand magnitudes.
  - Negate an operand if its op treats it as signed and its MSB is 1. MULHSU: only a is signed. MULHU/DIVU/REMU: neither.
  - Next state: MUL for mul ops; DIV for div/rem; DONE directly for a fast-path case.
- busy_o = (state==IDLE && start_i && !flush_i) || state==MUL || state==DIV. It is combinational so the M-op is held from its first EX cycle.
- MUL: radix-2 shift-add, 64-bit product register, 32 iterations. Counter runs 0..31; leave at count 31.
- DIV: restoring division, 32 iterations, 33-bit partial remainder. Same counter rule.
- Latency: start accepted in cycle 0, iterations in cycles 1–32, DONE in cycle 33. busy_o is high in cycles 0–32; done_o is high in cycle 33 only.
- DONE:
  - done_o=1 and res_o holds the final result (registered on entry).
  - start_i is ignored in DONE, because it is the same instruction leaving EX. Next state is IDLE unconditionally.
  - A back-to-back M-op starts in the following IDLE cycle.
- Sign fix on the final result:
  - MUL: low word. MULH/MULHSU/MULHU: high word, negated (64-bit) when the product sign is negative.
  - DIV/DIVU: quotient, negated if signed and the operand signs differ.
  - REM/REMU: remainder, sign taken from the dividend.
- Fast path (IDLE→DONE, busy_o in cycle 0 only, done_o in cycle 1):
  - Divide by zero: DIV/DIVU return 0xFFFF_FFFF; REM/REMU return opr_a.
  - Signed overflow (0x8000_0000 / 0xFFFF_FFFF): DIV returns 0x8000_0000; REM returns 0.
- flush_i:
  - In any state, the next state is IDLE and done_o is not asserted. busy_o drops in the same cycle flush_i is seen (flush has priority).
  - res_o keeps its old value.
- start_i falling during MUL/DIV without flush is illegal. An assertion flags it.
- done_o and res_o are registered. No combinational path from inputs to res_o.

Decomposition:
- mdu_pkg.svh (include-guarded, matching the existing stage packages) holds:
  - mduop_t enum, 3 bits, funct3 order.
  - mdu_state_t enum.
  - Constants: DIV0_Q = all-ones, MIN_INT = 0x8000_0000.
  - ex_mdu_in_t struct {mduop, opr_a, opr_b}, to be added to ex_stage_in_t later.
- Sub-module ex_mdu_dp holds the shift/add-subtract registers and the sign fix. It is controlled by load/step/finish strobes from the FSM in ex_mdu_seq.

Test Plan:
- MUL: a=7, b=-3 → busy_o 33 cycles, done_o at cycle 33, res_o=0xFFFF_FFEB. MULH with the same operands → 0xFFFF_FFFF.
- MULHU 0xFFFF_FFFF×0xFFFF_FFFF → 0xFFFF_FFFE. MULHSU a=-1, b=0xFFFF_FFFF → 0xFFFF_FFFF.
- DIV -20/3 → 0xFFFF_FFFA; REM -20/3 → 0xFFFF_FFFE; DIVU 100/7 → 14; REMU 100/7 → 2. Each takes 34 cycles total.
- Fast path:
  - DIV 5/0 → 0xFFFF_FFFF, REM 5/0 → 5.
  - DIV 0x8000_0000/-1 → 0x8000_0000, REM → 0.
  - Each with done_o in cycle 1 and busy_o in cycle 0 only.
- flush_i at cycle 10 of a DIV → busy_o low that cycle, no done_o, state IDLE. A new MUL 2×3 then returns 6 in 34 cycles.
- arst_n asserted mid-MUL → outputs 0 immediately. After release, back-to-back MUL 4×5 then DIVU 9/2 → res 20, then 4, with a one-cycle IDLE gap between them.
